// File: rtl/free_list_return_arbiter.sv
// Arbitrates the retire and squash paths onto the rename block's single free-register return port
// and tracks the free-register count. Optional FREE_RET_CHECK_EN enables sticky count_err checking.
module free_list_return_arbiter #(
    parameter int PHYS_W     = 5,
    parameter int NUM_PHYS   = 32,
    parameter int ARCH_REGS  = 8,
    parameter int LOW_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_valid,
    input  logic [PHYS_W-1:0] retire_reg,
    output logic              retire_ready,
    input  logic              squash_valid,
    input  logic [PHYS_W-1:0] squash_reg,
    output logic              squash_ready,
    input  logic              squash_active,
    input  logic              alloc,
    output logic              new_free,
    output logic [PHYS_W-1:0] new_free_reg,
    output logic [PHYS_W:0]   free_count,
    output logic              low_free,
    output logic              count_err
);

    localparam logic [PHYS_W:0] COUNT_MAX = (PHYS_W+1)'(NUM_PHYS);
    localparam logic [PHYS_W:0] COUNT_RST = (PHYS_W+1)'(NUM_PHYS - ARCH_REGS);
    localparam logic [PHYS_W:0] COUNT_LOW = (PHYS_W+1)'(LOW_THRESH);

    // Saturating count update: a grant and an alloc in the same cycle cancel out.
    function automatic logic [PHYS_W:0] next_count(input logic [PHYS_W:0] cur,
                                                   input logic            inc,
                                                   input logic            dec);
        logic [PHYS_W:0] res;
        res = cur;
        if (inc && !dec) begin
            res = cur + 1'b1;
        end else if (!inc && dec && (cur != '0)) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

    logic              full;
    logic              rr_last;
    logic              grant_retire_p0;
    logic              grant_squash_p0;
    logic              vld_p0;
    logic [PHYS_W-1:0] reg_p0;

    // Stage p0: combinational arbitration, readys are the grants themselves
    assign full = (free_count == COUNT_MAX);

    always_comb begin
        grant_retire_p0 = 1'b0;
        grant_squash_p0 = 1'b0;
        if (!full) begin
            if (squash_active) begin
                grant_squash_p0 = squash_valid;
            end else if (retire_valid && squash_valid) begin
                grant_retire_p0 = rr_last;
                grant_squash_p0 = !rr_last;
            end else begin
                grant_retire_p0 = retire_valid;
                grant_squash_p0 = squash_valid;
            end
        end
    end

    assign vld_p0       = grant_retire_p0 | grant_squash_p0;
    assign reg_p0       = grant_squash_p0 ? squash_reg : retire_reg;
    assign retire_ready = grant_retire_p0;
    assign squash_ready = grant_squash_p0;
    assign low_free     = (free_count <= COUNT_LOW);

    // Stage p1: registered return strobe, round-robin pointer and free count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_free     <= 1'b0;
            new_free_reg <= '0;
            free_count   <= COUNT_RST;
            rr_last      <= 1'b1;
        end else begin
            new_free   <= vld_p0;
            free_count <= next_count(free_count, vld_p0, alloc);
            if (vld_p0) begin
                new_free_reg <= reg_p0;
                rr_last      <= grant_squash_p0;
            end
        end
    end

`ifdef FREE_RET_CHECK_EN
    function automatic logic bad_idx(input logic [PHYS_W-1:0] idx);
        return ({1'b0, idx} >= COUNT_MAX);
    endfunction

    logic err_set;
    assign err_set = (alloc && (free_count == '0))
                   || (retire_valid && bad_idx(retire_reg))
                   || (squash_valid && bad_idx(squash_reg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_err <= 1'b0;
        end else if (err_set) begin
            count_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && err_set && !count_err) begin
            $error("free_list_return_arbiter: free count underflow or bad register index");
        end
    end
`endif
`else
    assign count_err = 1'b0;
`endif

endmodule
